mux_nway_reg: RTL and testbench
===============================

# mux_nway_reg

Parametrised NUM_INPUTS-to-1, DATA_WIDTH-bit selector with a registered output stage and a valid/ready handshake, backed by a one-entry skid buffer. It is the pipelined successor to the combinational 2-to-1 N-bit mux. It sits between datapath sources (register file, ALU, memory data, immediates) and multicycle-stage registers such as ALUOut and MDR, where the consumer may stall. The block also flags out-of-range selects.

## Interface
- DATA_WIDTH, 32, bits per input and output word
- NUM_INPUTS, 4, number of selectable inputs (2..16)
- SEL_WIDTH, 2, select width; must satisfy 2^SEL_WIDTH >= NUM_INPUTS
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_bus  input  NUM_INPUTS*DATA_WIDTH  flattened inputs; input k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
- select  input  SEL_WIDTH  index of input to capture
- in_valid  input  1  upstream presents select/in_bus this cycle
- in_ready  output  1  block can accept this cycle (registered)
- out  output  DATA_WIDTH  registered selected word
- out_sel  output  SEL_WIDTH  select value that produced out
- out_valid  output  1  out/out_sel valid
- out_ready  input  1  downstream accepts out this cycle
- sel_err  output  1  sticky flag: an out-of-range select was accepted

## Operation
- Transfer-in when in_valid && in_ready. Transfer-out when out_valid && out_ready.
- Captured word: in_bus slice [select]. If select >= NUM_INPUTS, the captured word is all zeros, out_sel = select, and sel_err is set.
- Storage has two levels:
  - main output register (out, out_sel, out_valid);
  - skid register (skid_data, skid_sel, skid_full).
- States:
  - EMPTY: out_valid=0, skid_full=0.
  - ONE: out_valid=1, skid_full=0.
  - FULL: out_valid=1, skid_full=1.
- Transitions:
  - EMPTY + transfer-in → ONE. The word loads into the main register.
  - ONE + transfer-in, no transfer-out → FULL. The word loads into skid.
  - ONE + transfer-in + transfer-out → ONE. The main register reloads with the new word.
  - ONE + transfer-out, no transfer-in → EMPTY.
  - FULL + transfer-out → ONE. Skid moves to main. No transfer-in is possible in FULL.
  - FULL, no transfer-out → FULL, all values held.
- in_ready registered: in_ready = !(next state == FULL).
- Ordering is strict FIFO: words leave in acceptance order.
- sel_err clears only on reset.
- out and out_sel hold their last value when out_valid=0. Consumers must ignore them in that case.

## Timing
- Reset values: out=0, out_sel=0, out_valid=0, in_ready=1, sel_err=0, skid_full=0, skid contents=0.
- Reset has priority over every other event, including a transfer mid-operation. All state returns to EMPTY on the edge where reset=1.
- Latency: a word accepted on edge N appears with out_valid=1 after edge N, so it is observable in cycle N+1.
- Throughput: one word per cycle while out_ready=1 continuously.
- in_ready is driven from flops only, with no combinational path from out_ready. in_valid/select/in_bus are ignored when in_ready=0.
- out_ready may toggle freely. out/out_sel/out_valid must stay stable while out_valid=1 and out_ready=0.
- sel_err asserts on the edge after the offending transfer-in.

## Test plan
- Reset, then drive in_bus inputs 0..3 = 0x11111111, 0x22222222, 0x33333333, 0x44444444, select=2, in_valid=1 for one cycle, out_ready=1 → next cycle out=0x33333333, out_sel=2, out_valid=1; following cycle out_valid=0.
- Streaming: out_ready=1 held, select=0,1,2,3 on four consecutive cycles → out sequence 0x11111111, 0x22222222, 0x33333333, 0x44444444 on four consecutive cycles, no bubbles.
- Backpressure: out_ready=0, send select=1 then select=3 → in_ready=0 after the second accept; out holds 0x22222222. Raise out_ready → 0x22222222 then 0x44444444, after which in_ready=1.
- Out-of-range select: NUM_INPUTS=3, SEL_WIDTH=2, select=3 accepted → out=0, out_sel=3, sel_err=1; sel_err stays 1 after further valid transfers.
- Reset mid-operation: in FULL with out_ready=0, assert reset for one cycle → out_valid=0, in_ready=1, sel_err=0, out=0. The next accepted word appears alone, with no stale skid data.
- Width/parameter sweep: DATA_WIDTH=8, NUM_INPUTS=16, SEL_WIDTH=4, random selects and random out_ready for 1000 cycles → output stream matches a scoreboard of accepted selects in order.

Source files
------------

// File: rtl/mux_nway_reg.sv
// NUM_INPUTS-to-1 word selector with a registered output stage, valid/ready
// handshake and a one-entry skid buffer; flags out-of-range selects.
module mux_nway_reg #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned SEL_WIDTH  = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_bus,
  input  logic [SEL_WIDTH-1:0]             select,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [DATA_WIDTH-1:0]            out,
  output logic [SEL_WIDTH-1:0]             out_sel,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             sel_err
);

  // One extra bit so NUM_INPUTS itself is representable in the range compare.
  localparam int unsigned CMP_W = SEL_WIDTH + 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   skid_data, skid_data_nxt;
  logic [SEL_WIDTH-1:0]    skid_sel, skid_sel_nxt;
  logic [DATA_WIDTH-1:0]   out_nxt;
  logic [SEL_WIDTH-1:0]    out_sel_nxt;
  logic                    out_valid_nxt;
  logic                    in_ready_nxt;
  logic                    sel_err_nxt;
  logic [DATA_WIDTH-1:0]   cap_word_c;
  logic                    sel_oor_c;
  logic                    xfer_in_c;
  logic                    xfer_out_c;

  // Word selection; an out-of-range select matches no slice and yields zero.
  always_comb begin
    cap_word_c = '0;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      if (select == SEL_WIDTH'(k)) begin
        cap_word_c = in_bus[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign sel_oor_c  = (CMP_W'(select) >= CMP_W'(NUM_INPUTS));
  assign xfer_in_c  = in_valid & in_ready;
  assign xfer_out_c = out_valid & out_ready;

  // Next-state and next-register values.
  always_comb begin
    state_nxt     = state;
    out_nxt       = out;
    out_sel_nxt   = out_sel;
    skid_data_nxt = skid_data;
    skid_sel_nxt  = skid_sel;
    sel_err_nxt   = sel_err | (xfer_in_c & sel_oor_c);

    case (state)
      EMPTY: begin
        if (xfer_in_c) begin
          out_nxt     = cap_word_c;
          out_sel_nxt = select;
          state_nxt   = ONE;
        end
      end
      ONE: begin
        if (xfer_in_c && xfer_out_c) begin
          out_nxt     = cap_word_c;
          out_sel_nxt = select;
        end else if (xfer_in_c) begin
          skid_data_nxt = cap_word_c;
          skid_sel_nxt  = select;
          state_nxt     = FULL;
        end else if (xfer_out_c) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only a drain can happen.
        if (xfer_out_c) begin
          out_nxt     = skid_data;
          out_sel_nxt = skid_sel;
          state_nxt   = ONE;
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase

    out_valid_nxt = (state_nxt != EMPTY);
    in_ready_nxt  = (state_nxt != FULL);
  end

  // All state, including the handshake outputs, comes straight from flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      out       <= '0;
      out_sel   <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      sel_err   <= 1'b0;
      skid_data <= '0;
      skid_sel  <= '0;
    end else begin
      state     <= state_nxt;
      out       <= out_nxt;
      out_sel   <= out_sel_nxt;
      out_valid <= out_valid_nxt;
      in_ready  <= in_ready_nxt;
      sel_err   <= sel_err_nxt;
      skid_data <= skid_data_nxt;
      skid_sel  <= skid_sel_nxt;
    end
  end

endmodule

// File: tb/tb_mux_nway_reg.sv
// Randomized bench for mux_nway_reg: three parameterisations checked against a
// two-deep FIFO reference model of accepted words.
module tb_mux_nway_reg;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Shared stimulus; only the active instance sees in_valid.
  int          act;
  logic [31:0] w [16];
  logic [3:0]  sel_s;
  logic        iv_s, ordy_s;

  // Instance A: 32-bit, 4 inputs; B: 32-bit, 3 inputs; C: 8-bit, 16 inputs.
  logic [127:0] bus_a;  logic [95:0] bus_b;  logic [127:0] bus_c;
  logic         ir_a, ir_b, ir_c, ov_a, ov_b, ov_c, se_a, se_b, se_c;
  logic [31:0]  out_a, out_b;  logic [7:0] out_c;
  logic [1:0]   os_a, os_b;    logic [3:0] os_c;

  always_comb begin
    for (int k = 0; k < 4; k++)  bus_a[k*32 +: 32] = w[k];
    for (int k = 0; k < 3; k++)  bus_b[k*32 +: 32] = w[k];
    for (int k = 0; k < 16; k++) bus_c[k*8 +: 8]   = w[k][7:0];
  end

  mux_nway_reg #(.DATA_WIDTH(32), .NUM_INPUTS(4), .SEL_WIDTH(2)) dut_a (
    .clk(clk), .reset(reset), .in_bus(bus_a), .select(sel_s[1:0]),
    .in_valid(iv_s && act == 0), .in_ready(ir_a), .out(out_a), .out_sel(os_a),
    .out_valid(ov_a), .out_ready(act == 0 ? ordy_s : 1'b1), .sel_err(se_a));

  mux_nway_reg #(.DATA_WIDTH(32), .NUM_INPUTS(3), .SEL_WIDTH(2)) dut_b (
    .clk(clk), .reset(reset), .in_bus(bus_b), .select(sel_s[1:0]),
    .in_valid(iv_s && act == 1), .in_ready(ir_b), .out(out_b), .out_sel(os_b),
    .out_valid(ov_b), .out_ready(act == 1 ? ordy_s : 1'b1), .sel_err(se_b));

  mux_nway_reg #(.DATA_WIDTH(8), .NUM_INPUTS(16), .SEL_WIDTH(4)) dut_c (
    .clk(clk), .reset(reset), .in_bus(bus_c), .select(sel_s),
    .in_valid(iv_s && act == 2), .in_ready(ir_c), .out(out_c), .out_sel(os_c),
    .out_valid(ov_c), .out_ready(act == 2 ? ordy_s : 1'b1), .sel_err(se_c));

  // Observed outputs of the active instance, zero-extended.
  logic [31:0] obs_d, obs_s;
  logic        obs_ir, obs_ov, obs_se;
  always_comb begin
    case (act)
      0:       begin obs_d = out_a; obs_s = 32'(os_a); obs_ir = ir_a; obs_ov = ov_a; obs_se = se_a; end
      1:       begin obs_d = out_b; obs_s = 32'(os_b); obs_ir = ir_b; obs_ov = ov_b; obs_se = se_b; end
      default: begin obs_d = 32'(out_c); obs_s = 32'(os_c); obs_ir = ir_c; obs_ov = ov_c; obs_se = se_c; end
    endcase
  end

  // Reference model: words in acceptance order, at most two held.
  typedef struct packed { logic [31:0] d; logic [31:0] s; } exp_t;
  exp_t q[$];
  logic serr [3];
  int   n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t act=%0d)", tag, got, exp, $time, act);
    end
  endtask

  function automatic exp_t predict();
    int          n;
    logic [31:0] mask, s;
    exp_t        e;
    n    = (act == 0) ? 4 : (act == 1) ? 3 : 16;
    mask = (act == 2) ? 32'h0000_00FF : 32'hFFFF_FFFF;
    s    = (act == 2) ? 32'(sel_s) : 32'(sel_s[1:0]);
    e.s  = s;
    e.d  = (int'(s) < n) ? (w[s] & mask) : 32'h0;
    return e;
  endfunction

  // One clock: sample handshake mid-cycle, update model, check after the edge.
  task automatic step();
    logic xin, xout, oor;
    exp_t e;
    #1;
    xin  = iv_s && obs_ir;
    xout = obs_ov && ordy_s;
    e    = predict();
    oor  = (act == 0) ? 1'b0 : (act == 1) ? (e.s >= 3) : 1'b0;
    @(posedge clk);
    if (reset) begin
      q.delete();
      for (int i = 0; i < 3; i++) serr[i] = 1'b0;
    end else begin
      if (xout) void'(q.pop_front());
      if (xin) begin
        q.push_back(e);
        if (oor) serr[act] = 1'b1;
      end
    end
    #1;
    check("out_valid", 32'(obs_ov), 32'(q.size() > 0));
    check("in_ready", 32'(obs_ir), 32'(q.size() < 2));
    check("sel_err", 32'(obs_se), 32'(serr[act]));
    if (q.size() > 0) begin
      check("out", obs_d, q[0].d);
      check("out_sel", obs_s, q[0].s);
    end
  endtask

  task automatic send(input int s, input logic v, input logic r);
    sel_s = 4'(s); iv_s = v; ordy_s = r;
    step();
  endtask

  initial begin
    act = 0; reset = 1'b1; iv_s = 1'b0; ordy_s = 1'b1; sel_s = '0;
    for (int k = 0; k < 16; k++) w[k] = 32'h0;
    for (int i = 0; i < 3; i++) serr[i] = 1'b0;
    w[0] = 32'h11111111; w[1] = 32'h22222222; w[2] = 32'h33333333; w[3] = 32'h44444444;
    step(); step();
    reset = 1'b0;
    check("rst_out", obs_d, 32'h0);
    check("rst_out_sel", obs_s, 32'h0);

    // Single word, then empty again.
    send(2, 1'b1, 1'b1);
    check("single_out", obs_d, 32'h33333333);
    send(0, 1'b0, 1'b1);
    send(0, 1'b0, 1'b1);

    // Streaming with no bubbles.
    for (int s = 0; s < 4; s++) send(s, 1'b1, 1'b1);
    send(0, 1'b0, 1'b1);
    send(0, 1'b0, 1'b1);

    // Backpressure: fill both levels, hold, then drain.
    send(1, 1'b1, 1'b0);
    send(3, 1'b1, 1'b0);
    check("bp_full_ready", 32'(obs_ir), 32'h0);
    send(2, 1'b1, 1'b0);
    send(2, 1'b1, 1'b0);
    check("bp_hold_out", obs_d, 32'h22222222);
    send(0, 1'b0, 1'b1);
    check("bp_drain1", obs_d, 32'h44444444);
    send(0, 1'b0, 1'b1);
    send(0, 1'b0, 1'b1);

    // Out-of-range select on the three-input instance, sticky flag.
    act = 1;
    send(3, 1'b1, 1'b1);
    check("oor_out", obs_d, 32'h0);
    check("oor_err", 32'(obs_se), 32'h1);
    for (int s = 0; s < 3; s++) send(s, 1'b1, 1'b1);
    send(0, 1'b0, 1'b1);
    check("oor_sticky", 32'(obs_se), 32'h1);

    // Reset while FULL and stalled.
    send(1, 1'b1, 1'b0);
    send(2, 1'b1, 1'b0);
    reset = 1'b1;
    send(0, 1'b0, 1'b0);
    reset = 1'b0;
    check("midrst_out", obs_d, 32'h0);
    check("midrst_err", 32'(obs_se), 32'h0);
    send(0, 1'b1, 1'b0);
    send(0, 1'b0, 1'b1);
    send(0, 1'b0, 1'b1);

    // Randomized sweep on the 8-bit, 16-input instance.
    act = 2;
    for (int c = 0; c < 1000; c++) begin
      for (int k = 0; k < 16; k++) w[k] = $urandom;
      send(int'($urandom_range(15, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    end
    for (int c = 0; c < 4; c++) send(0, 1'b0, 1'b1);
    check("sweep_drained", 32'(q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
